// File: rtl/countdown16_pkg.sv
// Shared constants and types for the countdown16 timer: state encodings and datapath width.
// Build option: define COUNTDOWN16_RELOAD_EN to enable periodic auto-reload.
`ifndef COUNTDOWN16_PKG_SV
`define COUNTDOWN16_PKG_SV
package countdown16_pkg;
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic load;
    logic start;
    logic pause;
    logic ack;
  } ctrl_t;
endpackage
`endif

// File: rtl/countdown16_zero.sv
// 16-input zero detector: nibble OR stage, then a 4-input OR, then the inverter.
module zero_detect16
  import countdown16_pkg::*;
(
  input  logic [CNT_W-1:0] d,
  output logic             z
);
  logic [3:0] nib_or;

  for (genvar i = 0; i < 4; i++) begin : g_nib
    assign nib_or[i] = |d[4*i +: 4];
  end

  assign z = ~(|nib_or);
endmodule

// File: rtl/countdown16.sv
// Loadable 16-bit down-counter with IDLE/RUN/DONE control and done/ack handshake.
// Define COUNTDOWN16_RELOAD_EN for periodic mode: done pulses and the count reloads.
module countdown16
  import countdown16_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  input  logic             ack,
  output logic [CNT_W-1:0] count,
  output logic             zero,
  output logic             busy,
  output logic             done
);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  ctrl_t            ctrl;

  assign ctrl = {load, start, pause, ack};

  zero_detect16 u_zero (.d(count_q), .z(zero));

`ifdef COUNTDOWN16_RELOAD_EN
  // Reload value only matters in periodic mode.
  logic [CNT_W-1:0] reload_q, reload_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) reload_q <= '0;
    else          reload_q <= reload_d;
  end

  always_comb begin
    reload_d = reload_q;
    if (ctrl.load) reload_d = load_val;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (ctrl.load) begin
      // load aborts whatever is in flight
      state_d = IDLE;
      count_d = load_val;
    end else begin
      case (state_q)
        IDLE: if (ctrl.start) state_d = zero ? DONE : RUN;
        RUN: begin
`ifdef COUNTDOWN16_RELOAD_EN
          if (zero) begin
            if (reload_q == '0) state_d = DONE;
            else                count_d = reload_q;
          end else if (!ctrl.pause) begin
            count_d = count_q - 1'b1;
          end
`else
          if (zero) begin
            state_d = DONE;
          end else if (!ctrl.pause) begin
            count_d = count_q - 1'b1;
            if (count_q == CNT_W'(1)) state_d = DONE;
          end
`endif
        end
        DONE: if (ctrl.ack) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign count = count_q;
  assign busy  = (state_q == RUN);
`ifdef COUNTDOWN16_RELOAD_EN
  // The cycle spent at zero in RUN is the one-cycle done pulse.
  assign done  = (state_q == DONE) || ((state_q == RUN) && zero);
`else
  assign done  = (state_q == DONE);
`endif
endmodule

// File: tb/tb_countdown16.sv
// Directed bench for countdown16: vector table plus hand sequences for pause, abort, reset, reload.
module tb_countdown16;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        load, start, pause, ack;
  logic [15:0] load_val;
  logic [15:0] count;
  logic        zero, busy, done;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    logic        load;
    logic [15:0] lval;
    logic        start;
    logic        pause;
    logic        ack;
    logic [15:0] ecount;
    logic        ebusy;
    logic        edone;
  } vec_t;

  countdown16 dut (
    .clk(clk), .reset_n(reset_n), .load(load), .load_val(load_val),
    .start(start), .pause(pause), .ack(ack),
    .count(count), .zero(zero), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic l, input logic [15:0] lv, input logic s, input logic p, input logic a);
    load = l; load_val = lv; start = s; pause = p; ack = a;
  endtask

  // Inputs are driven after a falling edge; outputs are sampled at the next falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_outs(input string name, input logic [15:0] c, input logic b, input logic d);
    chk({name, ".count"}, 32'(count), 32'(c));
    chk({name, ".busy"},  32'(busy),  32'(b));
    chk({name, ".done"},  32'(done),  32'(d));
    chk({name, ".zero"},  32'(zero),  32'(c == 16'd0));
  endtask

  initial begin
    int   n;
    logic seen;
`ifndef COUNTDOWN16_RELOAD_EN
    vec_t vecs[23];
    vecs[0]  = '{1'b1, 16'd5, 1'b0, 1'b0, 1'b0, 16'd5, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 16'd5, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 16'd4, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 16'd3, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 16'd2, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 16'd1, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 16'd0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 16'd0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 16'd0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 16'd0, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 16'd2, 1'b1, 1'b0, 1'b0, 16'd2, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 16'd0, 1'b1, 1'b0, 1'b1, 16'd2, 1'b1, 1'b0};
    vecs[16] = '{1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 16'd2, 1'b1, 1'b0};
    vecs[17] = '{1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 16'd1, 1'b1, 1'b0};
    vecs[18] = '{1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 16'd1, 1'b1, 1'b0};
    vecs[19] = '{1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1};
    vecs[20] = '{1'b1, 16'd7, 1'b0, 1'b0, 1'b1, 16'd7, 1'b0, 1'b0};
    vecs[21] = '{1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 16'd7, 1'b1, 1'b0};
    vecs[22] = '{1'b1, 16'd1, 1'b1, 1'b1, 1'b1, 16'd1, 1'b0, 1'b0};
`endif

    reset_n = 1'b0;
    drive(1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
    #12;
    chk_outs("reset", 16'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

`ifndef COUNTDOWN16_RELOAD_EN
    // one-shot: load 5 countdown, done/ack, load 0 -> DONE, priorities, pause
    for (int i = 0; i < 23; i++) begin
      drive(vecs[i].load, vecs[i].lval, vecs[i].start, vecs[i].pause, vecs[i].ack);
      cyc();
      chk_outs($sformatf("vec%0d", i), vecs[i].ecount, vecs[i].ebusy, vecs[i].edone);
    end
`endif

    // load 10, pause 3 cycles in RUN: done lands 13 cycles after start
    drive(1'b1, 16'd10, 1'b0, 1'b0, 1'b0); cyc();
    drive(1'b0, 16'd0, 1'b1, 1'b0, 1'b0);  cyc();
    n = 0;
    seen = 1'b0;
    for (int t = 1; t <= 40 && !seen; t++) begin
      drive(1'b0, 16'd0, 1'b0, (t >= 2 && t <= 4), 1'b0);
      cyc();
      if (t >= 2 && t <= 4) chk($sformatf("pause_hold%0d", t), 32'(count), 32'd9);
      if (done) begin seen = 1'b1; n = t; end
    end
    chk("pause_done_latency", 32'(n), 32'd13);
    chk("pause_final_count", 32'(count), 32'd0);
    drive(1'b0, 16'd0, 1'b0, 1'b0, 1'b1); cyc();

    // load 0xFFFF, run 100 cycles, abort with load 3
    drive(1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0); cyc();
    drive(1'b0, 16'd0, 1'b1, 1'b0, 1'b0);    cyc();
    drive(1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
    repeat (100) cyc();
    chk_outs("long_run", 16'hFF9B, 1'b1, 1'b0);
    drive(1'b1, 16'd3, 1'b0, 1'b0, 1'b0); cyc();
    chk_outs("abort_load", 16'd3, 1'b0, 1'b0);

    // asynchronous reset between edges at count 0x0040
    drive(1'b1, 16'h0050, 1'b0, 1'b0, 1'b0); cyc();
    drive(1'b0, 16'd0, 1'b1, 1'b0, 1'b0);    cyc();
    drive(1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
    repeat (16) cyc();
    chk_outs("pre_reset", 16'h0040, 1'b1, 1'b0);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1 chk_outs("async_reset", 16'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    cyc(); cyc();
    chk_outs("post_reset_idle", 16'd0, 1'b0, 1'b0);
    drive(1'b0, 16'd0, 1'b1, 1'b0, 1'b0); cyc();
    chk_outs("post_reset_start", 16'd0, 1'b0, 1'b1);
    drive(1'b0, 16'd0, 1'b0, 1'b0, 1'b1); cyc();
    chk_outs("post_reset_ack", 16'd0, 1'b0, 1'b0);

`ifdef COUNTDOWN16_RELOAD_EN
    // periodic mode: load 3 -> done pulses at 3, 7, 11 with busy held
    drive(1'b1, 16'd3, 1'b0, 1'b0, 1'b0); cyc();
    drive(1'b0, 16'd0, 1'b1, 1'b0, 1'b0); cyc();
    drive(1'b0, 16'd0, 1'b0, 1'b0, 1'b1);
    for (int t = 1; t <= 12; t++) begin
      logic [15:0] ec;
      cyc();
      case (t % 4)
        1: ec = 16'd2;
        2: ec = 16'd1;
        3: ec = 16'd0;
        default: ec = 16'd3;
      endcase
      chk_outs($sformatf("reload_t%0d", t), ec, 1'b1, (t == 3 || t == 7 || t == 11));
    end
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
